// File: rtl/cpu_pkg.sv
// CPU-wide constants and types shared by the fetch front end.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One buffered fetch: the instruction word and the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pair_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

  function automatic logic [XLEN-1:0] redirect_target(input logic [XLEN-1:0] bpc,
                                                      input logic [XLEN-1:0] imm);
    return bpc + imm;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small registered FIFO with synchronous flush. The caller must not push
// into a full FIFO unless it pops in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic             do_pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign do_pop = pop && !empty;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wrap_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= wrap_inc(rd_ptr);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: sequential PC, in-order memory requests, a {PC, instr}
// buffer toward decode, and branch redirect with stale-response dropping.
module ifetch_unit import cpu_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            Imem_req,
  output logic [XLEN-1:0] Imem_addr,
  input  logic            Imem_ready,
  input  logic            Imem_rvalid,
  input  logic [XLEN-1:0] Imem_rdata,
  input  logic            Branch_taken,
  input  logic [XLEN-1:0] Branch_pc,
  input  logic [XLEN-1:0] Imm_in,
  output logic            Instr_valid,
  output logic [XLEN-1:0] Instruction32,
  output logic [XLEN-1:0] Instr_pc,
  input  logic            Instr_ready,
  output logic            Misalign_err
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e    state;
  logic [XLEN-1:0] pc, resp_pc, target, target_al;
  logic [CW-1:0]   outstanding, drop_cnt, fifo_count;
  logic [CW:0]     inflight;
  logic            fifo_full, fifo_empty;
  logic            accept, resp, push, pop;
  fetch_pair_t     head, push_pair;

  assign target    = redirect_target(Branch_pc, Imm_in);
  assign target_al = {target[XLEN-1:2], 2'b00};

  assign Instr_valid   = !fifo_empty;
  assign Instruction32 = head.instr;
  assign Instr_pc      = head.pc;
  assign pop           = Instr_valid && Instr_ready;

  // A slot freed by this cycle's pop can already back a new request, which
  // keeps a two-entry buffer streaming one instruction per cycle.
  assign inflight  = {1'b0, outstanding} + {1'b0, fifo_count} - (CW+1)'(pop);
  assign Imem_req  = rst_n && !Branch_taken && (inflight < (CW+1)'(FIFO_DEPTH));
  assign Imem_addr = pc;
  assign accept    = Imem_req && Imem_ready;

  // Responses with nothing outstanding are protocol errors and are ignored.
  assign resp      = Imem_rvalid && (outstanding != '0);
  assign push      = resp && !Branch_taken && (drop_cnt == '0) && (!fifo_full || pop);
  assign push_pair = '{pc: resp_pc, instr: Imem_rdata};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_pair_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_pair),
    .pop       (pop),
    .flush     (Branch_taken),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_RUN;
      pc           <= RESET_PC;
      resp_pc      <= RESET_PC;
      outstanding  <= '0;
      drop_cnt     <= '0;
      Misalign_err <= 1'b0;
    end else begin
      Misalign_err <= Branch_taken && target[1];
      outstanding  <= outstanding + CW'(accept) - CW'(resp);
      if (Branch_taken) begin
        // A response landing in the redirect cycle is dropped here, so only
        // the ones still to come are counted.
        pc       <= target_al;
        resp_pc  <= target_al;
        drop_cnt <= outstanding - CW'(resp);
        state    <= ((outstanding - CW'(resp)) != '0) ? ST_DRAIN : ST_RUN;
      end else begin
        if (accept) pc      <= pc + XLEN'(4);
        if (push)   resp_pc <= resp_pc + XLEN'(4);
        case (state)
          ST_DRAIN: begin
            if (resp) begin
              drop_cnt <= drop_cnt - CW'(1);
              if (drop_cnt == CW'(1)) state <= ST_RUN;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with an in-order memory model whose
// response data is the bitwise inverse of the request address.
module tb_ifetch_unit;

  logic        clk, rst_n;
  logic        Imem_req, Imem_ready, Imem_rvalid;
  logic [31:0] Imem_addr, Imem_rdata;
  logic        Branch_taken;
  logic [31:0] Branch_pc, Imm_in;
  logic        Instr_valid, Instr_ready, Misalign_err;
  logic [31:0] Instruction32, Instr_pc;

  int          checks = 0;
  int          errors = 0;
  int          n_acc  = 0;
  int          n0;
  bit          ok;
  logic        rsp_en = 1'b1;
  logic        acc_l  = 1'b0;
  logic [31:0] addr_l = '0;
  logic [31:0] mq[$];

  ifetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .Imem_req      (Imem_req),
    .Imem_addr     (Imem_addr),
    .Imem_ready    (Imem_ready),
    .Imem_rvalid   (Imem_rvalid),
    .Imem_rdata    (Imem_rdata),
    .Branch_taken  (Branch_taken),
    .Branch_pc     (Branch_pc),
    .Imm_in        (Imm_in),
    .Instr_valid   (Instr_valid),
    .Instruction32 (Instruction32),
    .Instr_pc      (Instr_pc),
    .Instr_ready   (Instr_ready),
    .Misalign_err  (Misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Request handshake is sampled mid-cycle, when all inputs are settled.
  always @(negedge clk) begin
    acc_l  <= Imem_req && Imem_ready;
    addr_l <= Imem_addr;
  end

  // Zero-wait memory: a request accepted at an edge answers in the next cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      Imem_rvalid <= 1'b0;
      Imem_rdata  <= '0;
    end else begin
      if (acc_l) begin
        mq.push_back(addr_l);
        n_acc <= n_acc + 1;
      end
      if (rsp_en && mq.size() > 0) begin
        Imem_rvalid <= 1'b1;
        Imem_rdata  <= ~mq[0];
        void'(mq.pop_front());
      end else begin
        Imem_rvalid <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int lim, output bit found);
    found = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (Instr_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] exp_pc);
    chk1({tag, "_valid"}, Instr_valid, 1'b1);
    chk({tag, "_pc"}, Instr_pc, exp_pc);
    chk({tag, "_instr"}, Instruction32, ~exp_pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; Imem_ready = 1'b1; Branch_taken = 1'b0;
    Branch_pc = '0; Imm_in = '0; Instr_ready = 1'b1;

    // Reset state
    #12;
    chk1("rst_req", Imem_req, 1'b0);
    chk("rst_addr", Imem_addr, 32'h0);
    chk1("rst_valid", Instr_valid, 1'b0);
    chk("rst_instr", Instruction32, 32'h0);
    chk("rst_ipc", Instr_pc, 32'h0);
    chk1("rst_mis", Misalign_err, 1'b0);

    // Streaming from reset: PCs 0,4,8,12 back-to-back from cycle 2
    tick();
    rst_n = 1'b1;
    #1;
    chk1("first_req", Imem_req, 1'b1);
    chk("first_addr", Imem_addr, 32'h0);
    tick();
    chk1("c1_novalid", Instr_valid, 1'b0);
    tick();
    chk_head("stream0", 32'h0);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk_head("stream", 32'(4 * k));
    end

    // Mid-run reset, then decode stalled for 10 cycles
    rst_n = 1'b0;
    #1;
    chk1("async_rst_req", Imem_req, 1'b0);
    chk1("async_rst_valid", Instr_valid, 1'b0);
    Instr_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n0 = n_acc;
    repeat (3) tick();
    chk_head("stall_mid", 32'h0);
    repeat (7) tick();
    chk("stall_accepts", 32'(n_acc - n0), 32'd2);
    chk_head("stall_end", 32'h0);
    chk1("stall_req", Imem_req, 1'b0);
    Instr_ready = 1'b1;
    tick();
    chk_head("stall_resume", 32'h4);

    // Redirect with two requests outstanding: 0x100 + -16 -> 0xF0
    rst_n = 1'b0; rsp_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk1("two_out_req", Imem_req, 1'b0);
    Branch_taken = 1'b1; Branch_pc = 32'h100; Imm_in = 32'hFFFF_FFF0;
    tick();
    Branch_taken = 1'b0; rsp_en = 1'b1;
    chk("br_addr", Imem_addr, 32'h0F0);
    chk1("br_nomis", Misalign_err, 1'b0);
    wait_valid(20, ok);
    chk1("br_wait", ok, 1'b1);
    chk_head("br_first", 32'h0F0);
    tick();
    chk_head("br_second", 32'h0F4);

    // Misaligned redirect, coincident with a pop and a response
    repeat (2) tick();
    Branch_taken = 1'b1; Branch_pc = 32'h200; Imm_in = 32'h6;
    #1;
    chk1("mis_req_low", Imem_req, 1'b0);
    tick();
    Branch_taken = 1'b0;
    chk1("mis_pulse", Misalign_err, 1'b1);
    chk("mis_addr", Imem_addr, 32'h204);
    tick();
    chk1("mis_pulse_end", Misalign_err, 1'b0);
    wait_valid(20, ok);
    chk1("mis_wait", ok, 1'b1);
    chk_head("mis_first", 32'h204);
    tick();
    chk_head("mis_second", 32'h208);

    // Sequential PC wrap past 0xFFFFFFFC
    Branch_taken = 1'b1; Branch_pc = 32'hFFFF_FFF0; Imm_in = 32'h8;
    tick();
    Branch_taken = 1'b0;
    wait_valid(20, ok);
    chk1("seqwrap_wait", ok, 1'b1);
    chk_head("seqwrap_a", 32'hFFFF_FFF8);
    tick();
    chk_head("seqwrap_b", 32'hFFFF_FFFC);
    tick();
    chk_head("seqwrap_c", 32'h0);

    // Redirect target wraps: 0xFFFFFFFC + 8 -> 0x4
    Branch_taken = 1'b1; Branch_pc = 32'hFFFF_FFFC; Imm_in = 32'h8;
    tick();
    Branch_taken = 1'b0;
    chk("tgtwrap_addr", Imem_addr, 32'h4);
    wait_valid(20, ok);
    chk1("tgtwrap_wait", ok, 1'b1);
    chk_head("tgtwrap_first", 32'h4);

    // Reset while draining stale responses
    rsp_en = 1'b0;
    repeat (3) tick();
    Branch_taken = 1'b1; Branch_pc = 32'h300; Imm_in = 32'h2;
    tick();
    Branch_taken = 1'b0;
    chk1("drain_mis", Misalign_err, 1'b1);
    chk("drain_addr", Imem_addr, 32'h300);
    chk1("drain_req", Imem_req, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("drst_req", Imem_req, 1'b0);
    chk("drst_addr", Imem_addr, 32'h0);
    chk1("drst_valid", Instr_valid, 1'b0);
    chk("drst_instr", Instruction32, 32'h0);
    chk("drst_ipc", Instr_pc, 32'h0);
    chk1("drst_mis", Misalign_err, 1'b0);
    rsp_en = 1'b1;
    tick();
    rst_n = 1'b1;
    #1;
    chk1("restart_req", Imem_req, 1'b1);
    chk("restart_addr", Imem_addr, 32'h0);
    tick();
    tick();
    chk_head("restart_first", 32'h0);
    tick();
    chk_head("restart_second", 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
